cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Two-requester round-robin arbiter for a single-outstanding cache line fill port.
// Includes a BUSY watchdog that aborts a fill and raises a sticky timeout flag.
module cache_mem_arbiter #(
  parameter int LineSize      = 128,
  parameter int TimeoutCycles = 255
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [31:0]         c0_mem_addr_i,
  input  logic                c0_mem_read_en_i,
  output logic                c0_mem_read_valid_o,
  output logic [LineSize-1:0] c0_mem_read_data_o,
  input  logic [31:0]         c1_mem_addr_i,
  input  logic                c1_mem_read_en_i,
  output logic                c1_mem_read_valid_o,
  output logic [LineSize-1:0] c1_mem_read_data_o,
  output logic [31:0]         mem_addr_o,
  output logic                mem_read_en_o,
  input  logic                mem_read_valid_i,
  input  logic [LineSize-1:0] mem_read_data_i,
  output logic                timeout_err_o
);

  localparam int CntW = ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;
  // cnt_q holds the number of BUSY cycles already elapsed, so the last allowed one sees TimeoutCycles-1.
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;          // 1'b0 = requester 0, 1'b1 = requester 1
  logic            last_grant_q, last_grant_d;
  logic [31:0]     addr_q, addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            read_en_q, read_en_d;
  logic            sel;
  logic            fill_done;

  assign fill_done = (state_q == BUSY) && mem_read_valid_i;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    read_en_d    = read_en_q;
    sel          = 1'b0;

    if (c0_mem_read_en_i && c1_mem_read_en_i) begin
      sel = ~last_grant_q;
    end else if (c1_mem_read_en_i) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (c0_mem_read_en_i || c1_mem_read_en_i) begin
          state_d   = BUSY;
          grant_d   = sel;
          addr_d    = (sel ? c1_mem_addr_i : c0_mem_addr_i) & 32'hFFFF_FFF0;
          cnt_d     = '0;
          read_en_d = 1'b1;
        end else begin
          read_en_d = 1'b0;
        end
      end
      BUSY: begin
        // A data beat in the last watchdog cycle still counts as a normal completion.
        if (mem_read_valid_i) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          cnt_d        = '0;
          read_en_d    = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          err_d        = 1'b1;
          cnt_d        = '0;
          read_en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        read_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= 32'h0000_0000;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      read_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      read_en_q    <= read_en_d;
    end
  end

  assign mem_addr_o          = addr_q;
  assign mem_read_en_o       = read_en_q;
  assign timeout_err_o       = err_q;
  assign c0_mem_read_valid_o = fill_done && (grant_q == 1'b0);
  assign c1_mem_read_valid_o = fill_done && (grant_q == 1'b1);
  assign c0_mem_read_data_o  = mem_read_data_i;
  assign c1_mem_read_data_o  = mem_read_data_i;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed vector table, watchdog sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_cache_mem_arbiter;
  localparam int LS = 128;
  localparam int TO = 255;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [31:0]   c0_mem_addr_i, c1_mem_addr_i;
  logic          c0_mem_read_en_i, c1_mem_read_en_i;
  logic          c0_mem_read_valid_o, c1_mem_read_valid_o;
  logic [LS-1:0] c0_mem_read_data_o, c1_mem_read_data_o;
  logic [31:0]   mem_addr_o;
  logic          mem_read_en_o;
  logic          mem_read_valid_i;
  logic [LS-1:0] mem_read_data_i;
  logic          timeout_err_o;

  always #5 clk_i = ~clk_i;

  cache_mem_arbiter #(.LineSize(LS), .TimeoutCycles(TO)) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .c0_mem_addr_i       (c0_mem_addr_i),
    .c0_mem_read_en_i    (c0_mem_read_en_i),
    .c0_mem_read_valid_o (c0_mem_read_valid_o),
    .c0_mem_read_data_o  (c0_mem_read_data_o),
    .c1_mem_addr_i       (c1_mem_addr_i),
    .c1_mem_read_en_i    (c1_mem_read_en_i),
    .c1_mem_read_valid_o (c1_mem_read_valid_o),
    .c1_mem_read_data_o  (c1_mem_read_data_o),
    .mem_addr_o          (mem_addr_o),
    .mem_read_en_o       (mem_read_en_o),
    .mem_read_valid_i    (mem_read_valid_i),
    .mem_read_data_i     (mem_read_data_i),
    .timeout_err_o       (timeout_err_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a fill in flight, who owns it, how long it has been waiting.
  bit        m_busy, m_owner, m_last, m_err;
  logic [31:0] m_addr;
  int        m_age;

  typedef struct {
    logic rst; logic r0; logic r1; logic [31:0] a0; logic [31:0] a1; logic vld;
    logic en; logic [31:0] addr; logic v0; logic v1; logic err;
  } vec_t;
  vec_t tbl[25];

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_err = 1'b0; m_addr = 32'h0; m_age = 0;
  endtask

  task automatic model_edge();
    if (!rstn_i) begin
      model_reset();
    end else if (m_busy) begin
      m_age++;
      if (mem_read_valid_i) begin
        m_busy = 1'b0; m_last = m_owner;
      end else if (m_age == TO) begin
        m_busy = 1'b0; m_last = m_owner; m_err = 1'b1;
      end
    end else if (c0_mem_read_en_i || c1_mem_read_en_i) begin
      m_owner = (c0_mem_read_en_i && c1_mem_read_en_i) ? ~m_last : c1_mem_read_en_i;
      m_busy  = 1'b1;
      m_age   = 0;
      m_addr  = (m_owner ? c1_mem_addr_i : c0_mem_addr_i) & 32'hFFFF_FFF0;
    end
  endtask

  task automatic chk(input string nm, input logic [LS-1:0] act, input logic [LS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic en, input logic [31:0] addr,
                           input logic v0, input logic v1, input logic err, input bit chk_addr);
    chk({tag, "_en"}, LS'(mem_read_en_o), LS'(en));
    if (chk_addr) chk({tag, "_addr"}, LS'(mem_addr_o), LS'(addr));
    chk({tag, "_v0"}, LS'(c0_mem_read_valid_o), LS'(v0));
    chk({tag, "_v1"}, LS'(c1_mem_read_valid_o), LS'(v1));
    chk({tag, "_err"}, LS'(timeout_err_o), LS'(err));
    chk({tag, "_d0"}, c0_mem_read_data_o, mem_read_data_i);
    chk({tag, "_d1"}, c1_mem_read_data_o, mem_read_data_i);
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_busy, m_addr, m_busy && mem_read_valid_i && !m_owner,
              m_busy && mem_read_valid_i && m_owner, m_err, m_busy);
  endtask

  // Called at posedge+1; returns at the following negedge.
  task automatic drive(input logic rst, input logic r0, input logic r1,
                       input logic [31:0] a0, input logic [31:0] a1, input logic vld);
    rstn_i           = ~rst;
    c0_mem_read_en_i = r0;
    c1_mem_read_en_i = r1;
    c0_mem_addr_i    = a0;
    c1_mem_addr_i    = a1;
    mem_read_valid_i = vld;
    mem_read_data_i  = {$urandom, $urandom, $urandom, $urandom};
    if (rst) model_reset();
    #4;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  initial begin
    //               rst  r0   r1   a0            a1            vld   en   addr          v0   v1   err
    tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b0,32'h0000_1234,32'h0,        1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,32'h0000_1234,32'h0,        1'b0, 1'b1,32'h0000_1230,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,32'h0000_1234,32'h0,        1'b0, 1'b1,32'h0000_1230,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,32'h0000_1234,32'h0,        1'b1, 1'b1,32'h0000_1230,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b1,32'h0000_0104,32'h0000_200C,1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1,32'h0000_0104,32'h0000_200C,1'b0, 1'b1,32'h0000_0100,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,32'h0000_0104,32'h0000_200C,1'b1, 1'b1,32'h0000_0100,1'b1,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b1,32'h0000_0104,32'h0000_200C,1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b1,32'h0000_0104,32'h0000_200C,1'b1, 1'b1,32'h0000_2000,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b1,1'b1,32'h0000_0104,32'h0000_200C,1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b1,1'b1,32'h0000_0104,32'h0000_200C,1'b1, 1'b1,32'h0000_0100,1'b1,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b1,32'h0,        32'h0000_4444,1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,32'h0,        32'hFFFF_0000,1'b0, 1'b1,32'h0000_4440,1'b0,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b0,1'b0,32'h0,        32'hFFFF_0000,1'b1, 1'b1,32'h0000_4440,1'b0,1'b1,1'b0};
    tbl[18] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[19] = '{1'b0,1'b1,1'b0,32'h0000_5550,32'h0,        1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[20] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b1, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[21] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[22] = '{1'b0,1'b0,1'b1,32'h0,        32'h0000_6660,1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};
    tbl[23] = '{1'b0,1'b0,1'b1,32'h0,        32'h0000_6660,1'b1, 1'b1,32'h0000_6660,1'b0,1'b1,1'b0};
    tbl[24] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0, 1'b0,32'h0,        1'b0,1'b0,1'b0};

    rstn_i = 1'b0;
    c0_mem_read_en_i = 1'b0; c1_mem_read_en_i = 1'b0;
    c0_mem_addr_i = 32'h0; c1_mem_addr_i = 32'h0;
    mem_read_valid_i = 1'b0; mem_read_data_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1, tbl[i].vld);
      check_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].addr, tbl[i].v0, tbl[i].v1,
                tbl[i].err, tbl[i].en || tbl[i].rst);
      tick();
    end

    // Watchdog abort after TO silent BUSY cycles; flag stays set across a later fill.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_7777, 32'h0, 1'b0); tick();
    for (int k = 1; k <= TO; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      if (k == 1 || k == TO)
        check_all($sformatf("to_busy%0d", k), 1'b1, 32'h0000_7770, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_all("to_abort", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_9990, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_all("to_sticky_fill", 1'b1, 32'h0000_9990, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_all("to_sticky", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Data arriving in the very last watchdog cycle completes normally.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_all("to_clear", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_888F, 32'h0, 1'b0); tick();
    for (int k = 1; k < TO; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0000_888F, 32'h0, 1'b0);
      if (k == TO - 1)
        check_all("edge_wait", 1'b1, 32'h0000_8880, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_all("edge_done", 1'b1, 32'h0000_8880, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_all("edge_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Randomized traffic against the reference model.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); tick();
    for (int n = 0; n < 3000; n++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
